// File: rtl/oam_dma_pkg.sv
// Shared NES bus definitions: DMA state encoding and the fixed CPU/PPU register addresses.
package oam_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } dma_state_e;

    localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;
    localparam logic [7:0]  LAST_IDX      = 8'hFF;

    // True in every state in which the DMA owns the bus and the CPU is stalled.
    function automatic logic dma_owns_bus(input dma_state_e st);
        return (st != ST_IDLE);
    endfunction

endpackage

// File: rtl/oam_dma.sv
// Sprite OAM DMA engine: a CPU write to the DMA register stalls the CPU and copies a
// 256-byte page to the PPU OAM data port as read/write pairs aligned to the even cycle.
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = oam_dma_pkg::DMA_REG_ADDR,
    parameter logic [15:0] OAM_DATA_ADDR = oam_dma_pkg::OAM_DATA_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_nrw,
    output logic [7:0]  cpu_data_in,
    output logic        cpu_halt,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_data_out,
    output logic        bus_nrw,
    input  logic [7:0]  bus_data_in,
    output logic        dma_active
);

    dma_state_e  state_q, state_d;
    logic        parity_q, parity_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  data_latch_q, data_latch_d;
    logic        trigger_s;

    assign trigger_s = (cpu_nrw == 1'b0) && (cpu_addr == DMA_REG_ADDR);

    // State and datapath registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            parity_q     <= 1'b0;
            page_q       <= 8'h00;
            idx_q        <= 8'h00;
            data_latch_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            parity_q     <= parity_d;
            page_q       <= page_d;
            idx_q        <= idx_d;
            data_latch_q <= data_latch_d;
        end
    end

    // Next-state logic; parity is the free-running even/odd cycle marker.
    always_comb begin
        state_d      = state_q;
        parity_d     = ~parity_q;
        page_d       = page_q;
        idx_d        = idx_q;
        data_latch_d = data_latch_q;
        case (state_q)
            ST_IDLE: begin
                if (trigger_s) begin
                    page_d  = cpu_data_out;
                    idx_d   = 8'h00;
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                // An odd HALT cycle already puts the first READ on an even cycle.
                if (parity_q) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                state_d = ST_READ;
            end
            ST_READ: begin
                data_latch_d = bus_data_in;
                state_d      = ST_WRITE;
            end
            ST_WRITE: begin
                idx_d = idx_q + 8'h01;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_READ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus mux: CPU pass-through when idle, dummy reads while aligning, DMA pairs otherwise.
    always_comb begin
        bus_addr     = cpu_addr;
        bus_data_out = cpu_data_out;
        bus_nrw      = cpu_nrw;
        case (state_q)
            ST_IDLE: begin
                bus_nrw = cpu_nrw;
            end
            ST_HALT, ST_ALIGN: begin
                bus_nrw = 1'b1;
            end
            ST_READ: begin
                bus_addr = {page_q, idx_q};
                bus_nrw  = 1'b1;
            end
            ST_WRITE: begin
                bus_addr     = OAM_DATA_ADDR;
                bus_data_out = data_latch_q;
                bus_nrw      = 1'b0;
            end
            default: begin
                bus_nrw = cpu_nrw;
            end
        endcase
    end

    assign cpu_data_in = bus_data_in;
    assign cpu_halt    = dma_owns_bus(state_q);
    assign dma_active  = dma_owns_bus(state_q);

endmodule

// File: tb/tb_oam_dma.sv
// Directed/randomized bench for oam_dma against a transfer-level reference model.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_nrw;
    logic [7:0]  cpu_data_in;
    logic        cpu_halt;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data_out;
    logic        bus_nrw;
    logic [7:0]  bus_data_in;
    logic        dma_active;

    oam_dma dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_addr     (cpu_addr),
        .cpu_data_out (cpu_data_out),
        .cpu_nrw      (cpu_nrw),
        .cpu_data_in  (cpu_data_in),
        .cpu_halt     (cpu_halt),
        .bus_addr     (bus_addr),
        .bus_data_out (bus_data_out),
        .bus_nrw      (bus_nrw),
        .bus_data_in  (bus_data_in),
        .dma_active   (dma_active)
    );

    always #5 clk = ~clk;

    // System memory model answering every bus read.
    logic [7:0] mem [0:65535];
    assign bus_data_in = mem[bus_addr];

    // Reference cycle parity: number of clock edges since reset, modulo 2.
    int unsigned edge_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    int          checks = 0;
    int          failures = 0;
    int          inv_bad = 0;
    logic [7:0]  wr_q [$];
    logic [15:0] rd_q [$];
    logic [15:0] prev_addr = 16'h0000;
    logic        s_halt;
    logic        s_par;
    int          halted;
    logic        p_halt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive CPU inputs after the edge, then sample and monitor.
    task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic nrw,
                       input logic r = 1'b0);
        @(posedge clk);
        #2;
        rst = r; cpu_addr = a; cpu_data_out = d; cpu_nrw = nrw;
        #2;
        s_halt = cpu_halt;
        s_par  = edge_cnt[0];
        if (dma_active !== cpu_halt) inv_bad++;
        if (cpu_data_in !== bus_data_in) inv_bad++;
        if (cpu_halt === 1'b0 &&
            (bus_addr !== cpu_addr || bus_data_out !== cpu_data_out || bus_nrw !== cpu_nrw))
            inv_bad++;
        if (cpu_halt === 1'b1 && bus_nrw === 1'b0 && bus_addr !== 16'h2004) inv_bad++;
        if (bus_nrw === 1'b0 && bus_addr === 16'h2004) begin
            wr_q.push_back(bus_data_out);
            rd_q.push_back(prev_addr);
        end
        prev_addr = bus_addr;
    endtask

    task automatic idle();
        cyc(16'($urandom), 8'($urandom), 1'b1);
    endtask

    // Issue the trigger so that the HALT cycle lands on the requested parity.
    task automatic trigger(input logic [7:0] page, input logic want_p);
        idle();
        if (s_par != want_p) idle();
        wr_q.delete();
        rd_q.delete();
        cyc(16'h4014, page, 1'b0);
    endtask

    // mode 0: idle reads; 1: one DMA-register write at halted index wat; 2: write every cycle.
    task automatic wait_dma(input int mode, input logic [7:0] wpage, input int wat);
        halted = 0;
        p_halt = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (mode == 2 || (mode == 1 && halted == wat)) cyc(16'h4014, wpage, 1'b0);
            else idle();
            if (s_halt !== 1'b1) break;
            if (halted == 0) p_halt = s_par;
            halted++;
        end
    endtask

    // Reference: a transfer copies mem[{page,i}] for i = 0..255 to OAM in order.
    task automatic check_xfer(input logic [7:0] page);
        logic [15:0] a;
        chk("halted_cycles", 32'(halted), (p_halt ? 32'd513 : 32'd514));
        chk("halt_released", {31'd0, s_halt}, 32'd0);
        chk("oam_write_count", 32'(wr_q.size()), 32'd256);
        for (int i = 0; i < 256 && i < wr_q.size(); i++) begin
            a = {page, 8'(i)};
            chk("oam_write_data", {24'd0, wr_q[i]}, {24'd0, mem[a]});
            chk("read_addr", {16'd0, rd_q[i]}, {16'd0, a});
        end
    endtask

    initial begin
        rst = 1'b1; cpu_addr = 16'h0000; cpu_data_out = 8'h00; cpu_nrw = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i);

        // Reset: pass-through, no halt, trigger-like write ignored.
        cyc(16'h4014, 8'h55, 1'b0, 1'b1);
        chk("rst_halt", {31'd0, cpu_halt}, 32'd0);
        chk("rst_active", {31'd0, dma_active}, 32'd0);
        chk("rst_bus_addr", {16'd0, bus_addr}, 32'h4014);
        chk("rst_bus_data", {24'd0, bus_data_out}, 32'h55);
        chk("rst_bus_nrw", {31'd0, bus_nrw}, 32'd0);
        cyc(16'h1234, 8'h00, 1'b1, 1'b1);
        idle();
        chk("post_rst_no_dma", {31'd0, cpu_halt}, 32'd0);

        // Odd HALT: 513 halted cycles, data 00..FF from page 02.
        trigger(8'h02, 1'b1);
        wait_dma(0, 8'h00, 0);
        chk("odd_halt_parity", {31'd0, p_halt}, 32'd1);
        check_xfer(8'h02);

        // Even HALT: extra ALIGN cycle, identical data.
        trigger(8'h02, 1'b0);
        wait_dma(0, 8'h00, 0);
        chk("even_halt_parity", {31'd0, p_halt}, 32'd0);
        check_xfer(8'h02);

        // Write to DMA register at pair 100 is ignored; page stays 03.
        trigger(8'h03, 1'b1);
        wait_dma(1, 8'h07, 201);
        check_xfer(8'h03);

        // Back-to-back: writes held throughout DMA of page 04 retrigger on the first IDLE cycle.
        trigger(8'h04, 1'b0);
        wait_dma(2, 8'h05, 0);
        check_xfer(8'h04);
        wr_q.delete();
        rd_q.delete();
        wait_dma(0, 8'h00, 0);
        check_xfer(8'h05);

        // Reset during the READ of pair 37 aborts the transfer for good.
        trigger(8'h02, 1'b1);
        for (int k = 0; k < 75; k++) idle();
        cyc(16'h0BCD, 8'h3C, 1'b1, 1'b1);
        chk("abort_halt", {31'd0, cpu_halt}, 32'd0);
        chk("abort_active", {31'd0, dma_active}, 32'd0);
        chk("abort_bus_addr", {16'd0, bus_addr}, 32'h0BCD);
        chk("abort_writes_done", 32'(wr_q.size()), 32'd37);
        halted = 0;
        for (int k = 0; k < 600; k++) begin
            idle();
            if (s_halt === 1'b1) halted++;
        end
        chk("abort_no_resume", 32'(halted), 32'd0);
        chk("abort_no_more_writes", 32'(wr_q.size()), 32'd37);

        // Read of DMA register and write to a neighbour never trigger.
        cyc(16'h4014, 8'h11, 1'b1);
        chk("read_no_trigger", {31'd0, cpu_halt}, 32'd0);
        cyc(16'h4015, 8'hAA, 1'b0);
        chk("neighbour_halt", {31'd0, cpu_halt}, 32'd0);
        chk("neighbour_addr", {16'd0, bus_addr}, 32'h4015);
        chk("neighbour_data", {24'd0, bus_data_out}, 32'hAA);
        chk("neighbour_nrw", {31'd0, bus_nrw}, 32'd0);
        halted = 0;
        for (int k = 0; k < 4; k++) begin
            idle();
            if (s_halt === 1'b1) halted++;
        end
        chk("no_dma_after_neighbour", 32'(halted), 32'd0);

        chk("invariants", 32'(inv_bad), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
